// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake and feeds IF/ID.
// Load-use stalls park the fetched word in a one-entry hold buffer; late redirects drain the stale fetch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] instruction_if_id_o,
    output logic [31:0] pc_if_id_o,
    output logic        busywait_o,
    output logic        flush_o,
    output logic [1:0]  state_dbg_o
);

    // Handshake: a request is outstanding while imem_req_o=1 and completes on the
    // single cycle imem_ready_i=1; imem_addr_o never changes before that cycle.
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_stale_addr;
    logic [31:0] w_stale_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic [31:0] w_redirect_aligned;
    logic [31:0] w_pc_inc;

    assign w_redirect_aligned = {redirect_pc_i[31:2], 2'b00};
    assign w_pc_inc           = r_pc + 32'd4;
    assign state_dbg_o        = r_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_hold       <= NOP_INSTR;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_stale_addr <= w_stale_nxt;
            r_hold       <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stale_nxt = r_stale_addr;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_i) begin
                    w_pc_nxt = w_redirect_aligned;
                    // An unfinished fetch must still be drained at its original address.
                    if (!imem_ready_i) begin
                        w_stale_nxt = r_pc;
                        w_state_nxt = S_DROP;
                    end
                end else if (imem_ready_i && stall_i) begin
                    w_hold_nxt  = imem_rdata_i;
                    w_state_nxt = S_HOLD;
                end else if (imem_ready_i) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_redirect_aligned;
                    w_state_nxt = S_FETCH;
                end else if (!stall_i) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect_i) begin
                    w_pc_nxt = w_redirect_aligned;
                end
                if (imem_ready_i) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req_o          = 1'b0;
        imem_addr_o         = r_pc;
        instruction_if_id_o = NOP_INSTR;
        pc_if_id_o          = r_pc;
        busywait_o          = 1'b1;
        flush_o             = redirect_i;
        case (r_state)
            S_BOOT: begin
                pc_if_id_o = 32'd0;
                flush_o    = 1'b0;
            end
            S_FETCH: begin
                imem_req_o          = 1'b1;
                instruction_if_id_o = imem_rdata_i;
                busywait_o          = ~imem_ready_i;
            end
            S_HOLD: begin
                instruction_if_id_o = r_hold;
                busywait_o          = 1'b0;
            end
            S_DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = r_stale_addr;
            end
            default: begin
                flush_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: wait-state memory model, directed corner cases, then random
// stall/redirect traffic checked against an in-order instruction-stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;
    logic [31:0] instruction_if_id_o;
    logic [31:0] pc_if_id_o;
    logic        busywait_o;
    logic        flush_o;
    logic [1:0]  state_dbg_o;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_deliv = 0;

    // Redirect targets issued by the driver, consumed by the monitor on flush.
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    bit          prev_pending;

    int fixed_wait;
    int wait_left;
    bit mem_busy;

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i),
        .imem_ready_i(imem_ready_i),
        .instruction_if_id_o(instruction_if_id_o),
        .pc_if_id_o(pc_if_id_o),
        .busywait_o(busywait_o),
        .flush_o(flush_o),
        .state_dbg_o(state_dbg_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'h0050_0093;
        return {~a[15:0], a[17:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the falling edge; the monitor samples at +4.
    task automatic tick();
        @(negedge clk_i);
        #2;
    endtask

    task automatic run_to(input logic [31:0] a);
        int i;
        i = 0;
        while (!(imem_req_o && imem_addr_o == a) && i < 64) begin
            tick();
            i++;
        end
        chk("run_to_addr", imem_addr_o, a);
    endtask

    // ---------------- memory model ----------------
    always @(negedge clk_i) begin
        if (!imem_req_o) begin
            mem_busy     = 1'b0;
            imem_ready_i = 1'b0;
            imem_rdata_i = $urandom;
        end else begin
            if (!mem_busy) begin
                mem_busy  = 1'b1;
                wait_left = (fixed_wait < 0) ? int'($urandom_range(0, 2)) : fixed_wait;
            end
            if (wait_left == 0) begin
                imem_ready_i = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
                mem_busy     = 1'b0;
            end else begin
                imem_ready_i = 1'b0;
                imem_rdata_i = $urandom;
                wait_left--;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        logic [31:0] tgt;
        #4;
        if (rst_i) begin
            exp_q.delete();
            exp_pc       = RESET_PC;
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                chk("hs_req_held", {31'd0, imem_req_o}, 32'd1);
                chk("hs_addr_stable", imem_addr_o, prev_addr);
            end
            prev_pending = imem_req_o && !imem_ready_i;
            prev_addr    = imem_addr_o;
            if (exp_q.size() != 0) begin
                chk("flush_on_redirect", {31'd0, flush_o}, 32'd1);
                tgt    = exp_q.pop_front();
                exp_pc = {tgt[31:2], 2'b00};
            end else begin
                chk("flush_idle", {31'd0, flush_o}, 32'd0);
                if (!busywait_o && !stall_i) begin
                    n_deliv++;
                    chk("deliv_pc", pc_if_id_o, exp_pc);
                    chk("deliv_instr", instruction_if_id_o, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        rst_i         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ready_i  = 1'b0;
        imem_rdata_i  = 32'd0;
        fixed_wait    = 0;
        wait_left     = 0;
        mem_busy      = 1'b0;
        repeat (3) tick();

        // Reset / BOOT: redirect is ignored and flush stays low.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h44;
        #1;
        chk("boot_flush", {31'd0, flush_o}, 32'd0);
        tick();
        chk("boot_req", {31'd0, imem_req_o}, 32'd0);
        chk("boot_instr", instruction_if_id_o, NOP_INSTR);
        chk("boot_pc", pc_if_id_o, 32'd0);
        chk("boot_busy", {31'd0, busywait_o}, 32'd1);
        chk("boot_state", {30'd0, state_dbg_o}, 32'd0);
        rst_i      = 1'b0;
        redirect_i = 1'b0;

        // Zero-wait memory: one instruction per cycle from cycle 1.
        tick();
        chk("zw_req", {31'd0, imem_req_o}, 32'd1);
        chk("zw_addr0", imem_addr_o, 32'h0);
        chk("zw_busy0", {31'd0, busywait_o}, 32'd0);
        tick();
        chk("zw_addr4", imem_addr_o, 32'h4);
        chk("zw_busy4", {31'd0, busywait_o}, 32'd0);
        tick();
        chk("zw_addr8", imem_addr_o, 32'h8);
        chk("zw_busy8", {31'd0, busywait_o}, 32'd0);
        tick();
        chk("zw_addrc", imem_addr_o, 32'hC);
        fixed_wait = 2;

        // Two wait cycles at 0x10.
        tick();
        chk("ws_addr_a", imem_addr_o, 32'h10);
        chk("ws_busy_a", {31'd0, busywait_o}, 32'd1);
        tick();
        chk("ws_addr_b", imem_addr_o, 32'h10);
        chk("ws_busy_b", {31'd0, busywait_o}, 32'd1);
        tick();
        chk("ws_addr_c", imem_addr_o, 32'h10);
        chk("ws_busy_c", {31'd0, busywait_o}, 32'd0);
        fixed_wait = 0;
        tick();
        chk("ws_next_addr", imem_addr_o, 32'h14);
        chk("ws_next_pc", pc_if_id_o, 32'h14);

        // Load-use stall coinciding with ready at 0x20.
        run_to(32'h20);
        stall_i = 1'b1;
        #1;
        chk("st_busy", {31'd0, busywait_o}, 32'd0);
        chk("st_instr", instruction_if_id_o, 32'h0050_0093);
        tick();
        chk("hold_req", {31'd0, imem_req_o}, 32'd0);
        chk("hold_instr", instruction_if_id_o, 32'h0050_0093);
        chk("hold_pc", pc_if_id_o, 32'h20);
        chk("hold_busy", {31'd0, busywait_o}, 32'd0);
        tick();
        chk("hold_instr2", instruction_if_id_o, 32'h0050_0093);
        tick();
        stall_i = 1'b0;
        chk("hold_req3", {31'd0, imem_req_o}, 32'd0);
        tick();
        chk("after_hold_addr", imem_addr_o, 32'h24);
        chk("after_hold_req", {31'd0, imem_req_o}, 32'd1);

        // Redirect to misaligned 0x103 while 0x40 waits two cycles.
        run_to(32'h3C);
        fixed_wait = 2;
        tick();
        chk("rd_addr", imem_addr_o, 32'h40);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        exp_q.push_back(32'h103);
        #1;
        chk("rd_flush", {31'd0, flush_o}, 32'd1);
        chk("rd_busy", {31'd0, busywait_o}, 32'd1);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("drop_addr", imem_addr_o, 32'h40);
        chk("drop_instr", instruction_if_id_o, NOP_INSTR);
        chk("drop_busy", {31'd0, busywait_o}, 32'd1);
        chk("drop_flush", {31'd0, flush_o}, 32'd0);
        tick();
        chk("drop_addr2", imem_addr_o, 32'h40);
        fixed_wait = 0;
        tick();
        chk("rd_target", imem_addr_o, 32'h100);
        fixed_wait = 2;

        // Redirects while draining: the latest one wins.
        tick();
        chk("rd2_addr", imem_addr_o, 32'h104);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h150;
        exp_q.push_back(32'h150);
        tick();
        chk("rd2_drop_addr", imem_addr_o, 32'h104);
        redirect_pc_i = 32'h201;
        exp_q.push_back(32'h201);
        tick();
        redirect_i = 1'b0;
        fixed_wait = 0;
        tick();
        chk("rd2_target", imem_addr_o, 32'h200);

        // PC wrap at the top of the address space.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        exp_q.push_back(32'hFFFF_FFF8);
        tick();
        redirect_i = 1'b0;
        chk("wrap_fff8", imem_addr_o, 32'hFFFF_FFF8);
        tick();
        chk("wrap_fffc", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero", imem_addr_o, 32'h0);

        // Reset while a fetch of 0x80 is waiting.
        fixed_wait    = 2;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        exp_q.push_back(32'h80);
        tick();
        redirect_i = 1'b0;
        chk("mr_addr", imem_addr_o, 32'h80);
        chk("mr_busy", {31'd0, busywait_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        chk("mr_req", {31'd0, imem_req_o}, 32'd0);
        chk("mr_instr", instruction_if_id_o, NOP_INSTR);
        chk("mr_pc", pc_if_id_o, 32'd0);
        rst_i      = 1'b0;
        fixed_wait = 0;
        tick();
        chk("mr_restart_req", {31'd0, imem_req_o}, 32'd1);
        chk("mr_restart_addr", imem_addr_o, RESET_PC);

        // Random stalls, redirects and memory latency.
        fixed_wait = -1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall_i    = ($urandom_range(0, 3) == 0);
            redirect_i = ($urandom_range(0, 9) == 0);
            if (redirect_i) begin
                redirect_pc_i = $urandom;
                exp_q.push_back(redirect_pc_i);
            end
        end
        tick();
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        repeat (10) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("enough_deliveries", {31'd0, (n_deliv > 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
